// File: rtl/fir_fifo_engine.sv
// fir_fifo_engine: input FIFO feeding a sequential single-MAC FIR with a
// shadow/active coefficient bank, round-half-up, saturation, decimation and
// sticky error flags.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   data, wrreq               sample write into the FIFO
//   wrfull, usedw             FIFO full flag and occupancy
//   coef_we/addr/wdata        shadow bank write
//   coef_commit               request shadow->active copy at next IDLE
//   decim                     output decimation factor (0 acts as 1)
//   err_clr                   clear sticky errors
//   q, data_valid             filtered output and its one-cycle strobe
//   source_err                bit0 FIFO overflow, bit1 output saturation
//   monitor_fifout            last sample popped from the FIFO
module fir_fifo_engine #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned TAPS   = 16,
    parameter int unsigned SHIFT  = 14,
    parameter int unsigned OUT_W  = 18,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          data,
    input  logic                       wrreq,
    output logic                       wrfull,
    output logic [$clog2(DEPTH):0]     usedw,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic [COEF_W-1:0]          coef_wdata,
    input  logic                       coef_commit,
    input  logic [7:0]                 decim,
    input  logic                       err_clr,
    output logic [OUT_W-1:0]           q,
    output logic                       data_valid,
    output logic [1:0]                 source_err,
    output logic [DATA_W-1:0]          monitor_fifout
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CW     = $clog2(TAPS);
    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned ACC_W  = PROD_W + CW;
    localparam int unsigned SUM_W  = ACC_W + 1;

    localparam logic signed [SUM_W-1:0] RND    = SUM_W'(1) <<< (SHIFT - 1);
    localparam logic [COEF_W-1:0]       PASS   = COEF_W'(1) << SHIFT;
    localparam logic [CW:0]             TAPS_L = (CW + 1)'(TAPS);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_OUT} state_e;

    state_e                     state_q, state_d;
    logic [CW-1:0]              k_q, k_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [DATA_W-1:0]          x_q [TAPS];
    logic [DATA_W-1:0]          x_d [TAPS];
    logic [COEF_W-1:0]          cact_q [TAPS];
    logic [COEF_W-1:0]          cact_d [TAPS];
    logic [COEF_W-1:0]          csh_q [TAPS];
    logic [COEF_W-1:0]          csh_d [TAPS];
    logic                       pend_q, pend_d;
    logic [7:0]                 dec_q, dec_d;
    logic [7:0]                 dcnt_q, dcnt_d;
    logic [DATA_W-1:0]          mem [DEPTH];
    logic [AW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]                cnt_q, cnt_d;
    logic                       full_q, full_d;
    logic [1:0]                 err_q, err_d;
    logic [OUT_W-1:0]           q_q, q_d;
    logic                       dv_q, dv_d;
    logic [DATA_W-1:0]          mon_q, mon_d;

    logic                       push_c, pop_c;
    logic signed [PROD_W-1:0]   xs_c, cs_c, prod_c;
    logic signed [SUM_W-1:0]    sum_c, shr_c;
    logic                       sat_pos_c, sat_neg_c;
    logic [OUT_W-1:0]           res_c;

    assign wrfull         = full_q;
    assign usedw          = cnt_q;
    assign q              = q_q;
    assign data_valid     = dv_q;
    assign source_err     = err_q;
    assign monitor_fifout = mon_q;

    // FIFO storage; needs no reset since pointers gate every read
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wptr_q] <= data;
        end
    end

    // Next-state, datapath and output logic
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        x_d     = x_q;
        cact_d  = cact_q;
        csh_d   = csh_q;
        pend_d  = pend_q | coef_commit;
        dec_d   = dec_q;
        dcnt_d  = dcnt_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        err_d   = err_clr ? 2'b00 : err_q;
        q_d     = q_q;
        dv_d    = 1'b0;
        mon_d   = mon_q;

        // Full is judged on the registered count: a same-cycle pop never rescues a write
        push_c = wrreq && !full_q;
        pop_c  = (state_q == S_LOAD);
        if (push_c) wptr_d = wptr_q + AW'(1);
        if (pop_c)  rptr_d = rptr_q + AW'(1);
        cnt_d  = cnt_q + (AW + 1)'(push_c) - (AW + 1)'(pop_c);
        full_d = (cnt_d == (AW + 1)'(DEPTH));
        if (wrreq && full_q) err_d[0] = 1'b1;

        if (coef_we && ({1'b0, coef_addr} < TAPS_L)) begin
            csh_d[coef_addr] = coef_wdata;
        end

        xs_c   = {{COEF_W{x_q[k_q][DATA_W-1]}}, x_q[k_q]};
        cs_c   = {{DATA_W{cact_q[k_q][COEF_W-1]}}, cact_q[k_q]};
        prod_c = xs_c * cs_c;

        // Round half up, then clip to the signed OUT_W range
        sum_c     = $signed({acc_q[ACC_W-1], acc_q}) + RND;
        shr_c     = sum_c >>> SHIFT;
        sat_pos_c = !shr_c[SUM_W-1] && (|shr_c[SUM_W-2:OUT_W-1]);
        sat_neg_c = shr_c[SUM_W-1] && !(&shr_c[SUM_W-2:OUT_W-1]);
        if (sat_pos_c)      res_c = {1'b0, {(OUT_W - 1){1'b1}}};
        else if (sat_neg_c) res_c = {1'b1, {(OUT_W - 1){1'b0}}};
        else                res_c = shr_c[OUT_W-1:0];

        case (state_q)
            S_IDLE: begin
                // Commit has priority so a MAC never sees a half-updated bank
                if (pend_q) begin
                    cact_d = csh_q;
                    pend_d = coef_commit;
                end else if (cnt_q != '0) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                x_d[0] = mem[rptr_q];
                for (int i = 1; i < TAPS; i++) x_d[i] = x_q[i-1];
                mon_d   = mem[rptr_q];
                acc_d   = '0;
                k_d     = '0;
                dec_d   = (decim == 8'd0) ? 8'd1 : decim;
                state_d = S_MAC;
            end
            S_MAC: begin
                acc_d = acc_q + {{CW{prod_c[PROD_W-1]}}, prod_c};
                k_d   = k_q + CW'(1);
                if (k_q == CW'(TAPS - 1)) state_d = S_OUT;
            end
            S_OUT: begin
                // Saturation is flagged even when decimation drops the sample
                if (sat_pos_c || sat_neg_c) err_d[1] = 1'b1;
                if (dcnt_q >= dec_q - 8'd1) begin
                    dv_d   = 1'b1;
                    q_d    = res_c;
                    dcnt_d = 8'd0;
                end else begin
                    dcnt_d = dcnt_q + 8'd1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i]    <= '0;
                cact_q[i] <= (i == 0) ? PASS : '0;
                csh_q[i]  <= (i == 0) ? PASS : '0;
            end
            pend_q  <= 1'b0;
            dec_q   <= 8'd1;
            dcnt_q  <= 8'd0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            err_q   <= 2'b00;
            q_q     <= '0;
            dv_q    <= 1'b0;
            mon_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            cact_q  <= cact_d;
            csh_q   <= csh_d;
            pend_q  <= pend_d;
            dec_q   <= dec_d;
            dcnt_q  <= dcnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            err_q   <= err_d;
            q_q     <= q_d;
            dv_q    <= dv_d;
            mon_q   <= mon_d;
        end
    end

endmodule

// File: tb/tb_fir_fifo_engine.sv
// Bench for fir_fifo_engine: transaction-level convolution model with a queue
// of expected outputs, directed scenarios plus randomized coefficient/sample bursts.
module tb_fir_fifo_engine;

    localparam int DATA_W = 14;
    localparam int COEF_W = 16;
    localparam int TAPS   = 16;
    localparam int SHIFT  = 14;
    localparam int OUT_W  = 18;
    localparam int DEPTH  = 16;
    localparam longint QMAX = (longint'(1) <<< (OUT_W - 1)) - 1;
    localparam longint QMIN = -(longint'(1) <<< (OUT_W - 1));

    logic clk = 1'b0;
    logic rst;
    logic signed [DATA_W-1:0] data;
    logic wrreq;
    logic wrfull;
    logic [4:0] usedw;
    logic coef_we;
    logic [3:0] coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic coef_commit;
    logic [7:0] decim;
    logic err_clr;
    logic signed [OUT_W-1:0] q;
    logic data_valid;
    logic [1:0] source_err;
    logic signed [DATA_W-1:0] monitor_fifout;

    fir_fifo_engine #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS),
        .SHIFT(SHIFT), .OUT_W(OUT_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .wrreq(wrreq), .wrfull(wrfull),
        .usedw(usedw), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .coef_commit(coef_commit), .decim(decim),
        .err_clr(err_clr), .q(q), .data_valid(data_valid),
        .source_err(source_err), .monitor_fifout(monitor_fifout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dv_cnt = 0;
    int dv_cyc[$];
    longint exp_q[$];
    longint wq[$];
    longint cq[TAPS];
    longint m_act[TAPS];
    longint m_sh[TAPS];
    longint mx[TAPS];
    int m_since;
    logic [1:0] m_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Output monitor: every strobe must match the next modelled output
    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt++;
            dv_cyc.push_back(cyc);
            if (exp_q.size() == 0) check_val("spurious_dv", 1, 0);
            else check_val("q", longint'(q), exp_q.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int k = 0; k < TAPS; k++) begin
            m_act[k] = (k == 0) ? (longint'(1) <<< SHIFT) : 0;
            m_sh[k]  = m_act[k];
            mx[k]    = 0;
        end
        m_since = 0;
        m_err   = 2'b00;
        exp_q.delete();
    endfunction

    // One accepted sample: full convolution, round half up, clip, decimate
    function automatic void model_sample(input longint v, input int dec);
        longint acc;
        longint r;
        for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = v;
        acc = 0;
        for (int k = 0; k < TAPS; k++) acc += mx[k] * m_act[k];
        r = (acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        if (r > QMAX) begin r = QMAX; m_err[1] = 1'b1; end
        if (r < QMIN) begin r = QMIN; m_err[1] = 1'b1; end
        m_since++;
        if (m_since >= dec) begin
            exp_q.push_back(r);
            m_since = 0;
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic write_wq();
        int dec;
        dec = (decim == 8'd0) ? 1 : int'(decim);
        foreach (wq[i]) begin
            data  = DATA_W'(wq[i]);
            wrreq = 1'b1;
            model_sample(wq[i], dec);
            tick();
        end
        wrreq = 1'b0;
        wq.delete();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (usedw != 0 && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) check_val("drain_timeout", 1, 0);
        repeat (TAPS + 6) tick();
    endtask

    task automatic load_coefs();
        for (int k = 0; k < TAPS; k++) begin
            coef_we    = 1'b1;
            coef_addr  = 4'(k);
            coef_wdata = COEF_W'(cq[k]);
            m_sh[k]    = cq[k];
            tick();
        end
        coef_we     = 1'b0;
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
        repeat (3) tick();
        m_act = m_sh;
    endtask

    task automatic latency_probe(input longint v);
        int n;
        int c0;
        wq.push_back(v);
        write_wq();
        n = 0;
        while (monitor_fifout != DATA_W'(v) && n < 100) begin tick(); n++; end
        check_val("monitor_fifout", longint'(monitor_fifout), v);
        c0 = cyc;
        n = 0;
        while (!data_valid && n < 100) begin tick(); n++; end
        check_val("pop_to_valid", longint'(cyc - c0), TAPS + 1);
    endtask

    initial begin
        int start;
        rst = 1'b1; data = '0; wrreq = 1'b0; coef_we = 1'b0; coef_addr = '0;
        coef_wdata = '0; coef_commit = 1'b0; decim = 8'd1; err_clr = 1'b0;
        repeat (2) tick();
        do_reset();

        check_val("rst_q", longint'(q), 0);
        check_val("rst_dv", longint'(data_valid), 0);
        check_val("rst_err", longint'(source_err), 0);
        check_val("rst_mon", longint'(monitor_fifout), 0);
        check_val("rst_usedw", longint'(usedw), 0);
        check_val("rst_wrfull", longint'(wrfull), 0);

        // Passthrough with latency measurement, then back-to-back throughput
        latency_probe(100);
        drain();
        latency_probe(-8192);
        drain();
        dv_cyc.delete();
        wq = '{5, -6, 7};
        write_wq();
        drain();
        check_val("dv_count_burst", longint'(dv_cyc.size()), 3);
        if (dv_cyc.size() == 3) begin
            check_val("throughput0", longint'(dv_cyc[1] - dv_cyc[0]), TAPS + 3);
            check_val("throughput1", longint'(dv_cyc[2] - dv_cyc[1]), TAPS + 3);
        end

        // Impulse response through a programmed bank
        for (int k = 0; k < TAPS; k++) cq[k] = 1024 * (k + 1);
        load_coefs();
        wq.push_back(16);
        for (int i = 0; i < 15; i++) wq.push_back(0);
        write_wq();
        drain();
        check_val("impulse_last", longint'(q), 16);
        wq.push_back(0);
        write_wq();
        drain();
        check_val("impulse_flush", longint'(q), 0);

        // Randomized banks, samples and decimation
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < TAPS; k++) cq[k] = longint'($urandom_range(8191)) - 4096;
            load_coefs();
            decim = 8'($urandom_range(3));
            for (int b = 0; b < 2; b++) begin
                int n;
                n = int'($urandom_range(16, 1));
                for (int i = 0; i < n; i++) wq.push_back(longint'($urandom_range(16383)) - 8192);
                write_wq();
                drain();
            end
        end
        check_val("rand_err", longint'(source_err), longint'(m_err));
        check_val("rand_left", longint'(exp_q.size()), 0);
        err_clr = 1'b1; tick(); err_clr = 1'b0; m_err = 2'b00;

        // Saturation both ways, then clear
        do_reset();
        for (int k = 0; k < TAPS; k++) cq[k] = 32767;
        load_coefs();
        for (int i = 0; i < 16; i++) wq.push_back(8191);
        write_wq();
        drain();
        check_val("sat_pos_q", longint'(q), 131071);
        check_val("sat_pos_err", longint'(source_err), 2);
        for (int i = 0; i < 16; i++) wq.push_back(-8192);
        write_wq();
        drain();
        check_val("sat_neg_q", longint'(q), -131072);
        err_clr = 1'b1; tick(); err_clr = 1'b0; m_err = 2'b00;
        check_val("sat_clr", longint'(source_err), 0);

        // Overflow while the engine is held in IDLE by a standing commit
        for (int k = 0; k < TAPS; k++) cq[k] = (k == 0) ? 16384 : 0;
        load_coefs();
        coef_commit = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 17; i++) begin
            data  = DATA_W'(i + 1);
            wrreq = 1'b1;
            if (i < 16) model_sample(longint'(i + 1), 1);
            tick();
        end
        wrreq = 1'b0;
        m_err[0] = 1'b1;
        check_val("ovf_wrfull", longint'(wrfull), 1);
        check_val("ovf_usedw", longint'(usedw), 16);
        check_val("ovf_err", longint'(source_err), 1);
        coef_commit = 1'b0;
        drain();
        check_val("ovf_left", longint'(exp_q.size()), 0);
        check_val("ovf_last_q", longint'(q), 16);
        err_clr = 1'b1; tick(); err_clr = 1'b0; m_err = 2'b00;
        check_val("ovf_clr", longint'(source_err), 0);

        // Decimation by 4, then 0 behaving as 1
        do_reset();
        decim = 8'd4;
        start = dv_cnt;
        for (int i = 1; i <= 12; i++) wq.push_back(i);
        write_wq();
        drain();
        check_val("decim4_count", longint'(dv_cnt - start), 3);
        check_val("decim4_q", longint'(q), 12);
        decim = 8'd0;
        start = dv_cnt;
        wq = '{7, 8, 9};
        write_wq();
        drain();
        check_val("decim0_count", longint'(dv_cnt - start), 3);
        check_val("decim0_q", longint'(q), 9);

        // Reset in the middle of a MAC
        decim = 8'd1;
        for (int k = 0; k < TAPS; k++) cq[k] = (k < 2) ? 8192 : 0;
        load_coefs();
        wq.push_back(1000);
        write_wq();
        begin
            int n;
            n = 0;
            while (monitor_fifout != DATA_W'(1000) && n < 100) begin tick(); n++; end
        end
        repeat (3) tick();
        do_reset();
        start = dv_cnt;
        repeat (TAPS + 10) tick();
        check_val("midrst_dv", longint'(dv_cnt - start), 0);
        check_val("midrst_usedw", longint'(usedw), 0);
        check_val("midrst_q", longint'(q), 0);
        check_val("midrst_err", longint'(source_err), 0);
        wq.push_back(55);
        write_wq();
        drain();
        check_val("midrst_pass", longint'(q), 55);
        check_val("final_left", longint'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
